// File: rtl/pixel_stream_reader.sv
// Raster pixel fetcher: reads LANES-wide beats from frame memory, applies a per-frame point op.
// Optional BMP_BOTTOM_UP_EN fetches rows bottom-up; timing is identical in both builds.
module pixel_stream_reader #(
  parameter int IMAGE_WIDTH  = 768,
  parameter int IMAGE_HEIGHT = 512,
  parameter int PIXEL_WIDTH  = 8,
  parameter int LANES        = 2,
  parameter int START_DELAY  = 100,
  parameter int HSYNC_DELAY  = 160,
  parameter int THRESHOLD    = 90,
  parameter int BRIGHTNESS   = 50,
  parameter int ADDR_WIDTH   = 18
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [1:0]                         mode,
  output logic                               mem_rd_en,
  output logic [ADDR_WIDTH-1:0]              mem_addr,
  input  logic [3*LANES*PIXEL_WIDTH-1:0]     mem_rd_data,
  input  logic                               mem_rd_valid,
  output logic [LANES*PIXEL_WIDTH-1:0]       data_R,
  output logic [LANES*PIXEL_WIDTH-1:0]       data_G,
  output logic [LANES*PIXEL_WIDTH-1:0]       data_B,
  output logic                               vertical_Pulse,
  output logic                               horizontal_Pulse,
  output logic                               done_Flag
);

  localparam int PW      = PIXEL_WIDTH;
  localparam int BEATS   = IMAGE_WIDTH / LANES;
  localparam int CNT_MAX = (START_DELAY > HSYNC_DELAY) ? START_DELAY : HSYNC_DELAY;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int RW      = $clog2(IMAGE_HEIGHT + 1);
  localparam int CLW     = $clog2(BEATS + 1);
  localparam int SW      = PW + 2;
  localparam logic [PW-1:0] PMAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_REQ, S_WAIT, S_HSYNC, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [RW-1:0]           row_q, row_d, row_eff;
  logic [CLW-1:0]          col_q, col_d;
  logic [1:0]              mode_q, mode_d;
  logic                    vpulse_q, vpulse_d, hpulse_q, hpulse_d, done_q, done_d;
  logic [LANES*PW-1:0]     r_q, r_d, g_q, g_d, b_q, b_d;
  logic [LANES*PW-1:0]     proc_r, proc_g, proc_b;

  // Returns {b,g,r} after the selected point operation.
  function automatic logic [3*PW-1:0] point_op(input logic [1:0] m, input logic [PW-1:0] r,
                                               input logic [PW-1:0] g, input logic [PW-1:0] b);
    logic [SW-1:0] sum;
    logic [PW:0]   br, bg, bb;
    sum = SW'(r) + SW'(g) + SW'(b);
    br  = {1'b0, r} + (PW+1)'(BRIGHTNESS);
    bg  = {1'b0, g} + (PW+1)'(BRIGHTNESS);
    bb  = {1'b0, b} + (PW+1)'(BRIGHTNESS);
    case (m)
      2'd1:    point_op = (sum > SW'(3*THRESHOLD)) ? {PMAX, PMAX, PMAX} : '0;
      2'd2:    point_op = {bb[PW] ? PMAX : bb[PW-1:0], bg[PW] ? PMAX : bg[PW-1:0],
                           br[PW] ? PMAX : br[PW-1:0]};
      2'd3:    point_op = {~b, ~g, ~r};
      default: point_op = {b, g, r};
    endcase
  endfunction

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign {proc_b[l*PW +: PW], proc_g[l*PW +: PW], proc_r[l*PW +: PW]} =
      point_op(mode_q, mem_rd_data[l*3*PW +: PW], mem_rd_data[l*3*PW+PW +: PW],
               mem_rd_data[l*3*PW+2*PW +: PW]);
  end

`ifdef BMP_BOTTOM_UP_EN
  assign row_eff = RW'(IMAGE_HEIGHT - 1) - row_q;
`else
  assign row_eff = row_q;
`endif

  assign mem_rd_en = (state_q == S_REQ);
  assign mem_addr  = mem_rd_en ? (ADDR_WIDTH'(row_eff) * ADDR_WIDTH'(BEATS) + ADDR_WIDTH'(col_q))
                               : '0;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    row_d    = row_q;
    col_d    = col_q;
    mode_d   = mode_q;
    done_d   = done_q;
    vpulse_d = 1'b0;
    hpulse_d = 1'b0;
    r_d      = r_q;
    g_d      = g_q;
    b_d      = b_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          mode_d   = mode;
          done_d   = 1'b0;
          row_d    = '0;
          col_d    = '0;
          vpulse_d = 1'b1;
          cnt_d    = CW'(START_DELAY - 1);
          state_d  = S_VSYNC;
        end
      end
      S_VSYNC, S_HSYNC: begin
        if (cnt_q == '0) state_d = S_REQ;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_REQ: state_d = S_WAIT;
      S_WAIT: begin
        if (mem_rd_valid) begin
          hpulse_d = 1'b1;
          r_d      = proc_r;
          g_d      = proc_g;
          b_d      = proc_b;
          if (col_q == CLW'(BEATS - 1)) begin
            col_d = '0;
            if (row_q == RW'(IMAGE_HEIGHT - 1)) begin
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              row_d   = row_q + RW'(1);
              cnt_d   = CW'(HSYNC_DELAY - 1);
              state_d = S_HSYNC;
            end
          end else begin
            col_d   = col_q + CLW'(1);
            state_d = S_REQ;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      mode_q   <= '0;
      vpulse_q <= 1'b0;
      hpulse_q <= 1'b0;
      done_q   <= 1'b0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      row_q    <= row_d;
      col_q    <= col_d;
      mode_q   <= mode_d;
      vpulse_q <= vpulse_d;
      hpulse_q <= hpulse_d;
      done_q   <= done_d;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
    end
  end

  assign data_R           = r_q;
  assign data_G           = g_q;
  assign data_B           = b_q;
  assign vertical_Pulse   = vpulse_q;
  assign horizontal_Pulse = hpulse_q;
  assign done_Flag        = done_q;

endmodule
